// File: rtl/tg_loader_pkg.sv
// Shared definitions for the target code loader: FSM states, stream framing sizes
// and the default target-reset hold value.
package tg_loader_pkg;

    localparam int unsigned LEN_BYTES          = 2;
    localparam int unsigned WORD_BYTES         = 2;
    localparam logic        RESET_HOLD_DEFAULT = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        CHK,
        W_LO,
        W_HI,
        WRITE,
`ifdef TG_LOADER_VERIFY_EN
        VRD,
        VCMP,
`endif
        RELEASE,
        ERR
    } state_t;

endpackage

// File: rtl/le16_assembler.sv
// Little-endian byte-pair capture register; word_valid pulses the cycle after the
// high byte is captured, when the assembled word is first visible.
module le16_assembler
    import tg_loader_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                byte_in,
    input  logic                      load_lo,
    input  logic                      load_hi,
    output logic [8*WORD_BYTES-1:0]   word,
    output logic                      word_valid
);

    logic [7:0] lo_byte;
    logic [7:0] hi_byte;

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lo_byte    <= '0;
            hi_byte    <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= load_hi;
            if (load_lo) lo_byte <= byte_in;
            if (load_hi) hi_byte <= byte_in;
        end
    end

    assign word = {hi_byte, lo_byte};

endmodule

// File: rtl/tg_code_loader.sv
// UART-fed loader for the target code RAM: reads a 16-bit word count and that many
// opcodes, writes them from address 0, then releases target reset.
// Optional read-back check of every written word: define TG_LOADER_VERIFY_EN.
module tg_code_loader
    import tg_loader_pkg::*;
#(
    parameter int unsigned ADDR_W     = 12,
    parameter logic        RESET_HOLD = RESET_HOLD_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] m9k_addr,
    output logic [15:0]       m9k_data,
    output logic              m9k_we,
    input  logic [15:0]       m9k_q,
    output logic              tg_reset,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       word_count
);

    localparam int unsigned CAPACITY = 32'd1 << ADDR_W;

    state_t                  state;
    logic [15:0]             idx;
    logic [15:0]             idx_next;
    logic                    accept;
    logic [8*LEN_BYTES-1:0]  len_word;
    logic                    len_valid;
    logic [8*WORD_BYTES-1:0] dat_word;
    logic                    dat_valid;

    assign accept   = rx_valid & rx_ready;
    assign idx_next = idx + 16'd1;

    le16_assembler u_len (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (rx_data),
        .load_lo    (accept && state == LEN_LO),
        .load_hi    (accept && state == LEN_HI),
        .word       (len_word),
        .word_valid (len_valid)
    );

    le16_assembler u_dat (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (rx_data),
        .load_lo    (accept && state == W_LO),
        .load_hi    (accept && state == W_HI),
        .word       (dat_word),
        .word_valid (dat_valid)
    );

    assign word_count = len_word;
    // The opcode register already holds the word for the whole WRITE (and verify) window.
    assign m9k_data   = dat_word;

`ifndef TG_LOADER_VERIFY_EN
    logic unused_q;
    assign unused_q = ^m9k_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rx_ready <= 1'b0;
            m9k_we   <= 1'b0;
            m9k_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            tg_reset <= RESET_HOLD;
            idx      <= '0;
        end else begin
            m9k_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE, ERR: begin
                    if (start) begin
                        tg_reset <= 1'b1;
                        err      <= 1'b0;
                        idx      <= '0;
                        busy     <= 1'b1;
                        rx_ready <= 1'b1;
                        state    <= LEN_LO;
                    end
                end
                LEN_LO: if (accept) state <= LEN_HI;
                LEN_HI: begin
                    if (accept) begin
                        rx_ready <= 1'b0;
                        state    <= CHK;
                    end
                end
                CHK: begin
                    if (len_valid) begin
                        if (len_word == '0) begin
                            tg_reset <= 1'b0;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state    <= RELEASE;
                        end else if (32'(len_word) > CAPACITY) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= ERR;
                        end else begin
                            rx_ready <= 1'b1;
                            state    <= W_LO;
                        end
                    end
                end
                W_LO: if (accept) state <= W_HI;
                W_HI: begin
                    if (accept) begin
                        rx_ready <= 1'b0;
                        m9k_we   <= 1'b1;
                        m9k_addr <= idx[ADDR_W-1:0];
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (dat_valid) begin
                        idx <= idx_next;
`ifdef TG_LOADER_VERIFY_EN
                        state <= VRD;
`else
                        if (idx_next == len_word) begin
                            tg_reset <= 1'b0;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state    <= RELEASE;
                        end else begin
                            rx_ready <= 1'b1;
                            state    <= W_LO;
                        end
`endif
                    end
                end
`ifdef TG_LOADER_VERIFY_EN
                VRD: state <= VCMP;
                VCMP: begin
                    // idx was already advanced in WRITE, so it now counts written words.
                    if (m9k_q != dat_word) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= ERR;
                    end else if (idx == len_word) begin
                        tg_reset <= 1'b0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= RELEASE;
                    end else begin
                        rx_ready <= 1'b1;
                        state    <= W_LO;
                    end
                end
`endif
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
